// File: rtl/axis_pkt_gen.sv
// axis_pkt_gen: AXI4-Stream master that emits incrementing-word packets.
// A start pulse latches the byte length and seed. The block then sends
// ceil(len/4) beats with tdata = seed + k. The final beat carries tlast and a
// partial tkeep when len is not a multiple of 4. A zero-length start is
// rejected with an err pulse.
// Optional feature macro: AXIS_PKT_GEN_GAP_EN adds cfg_gap[7:0]. It inserts
// cfg_gap idle (tvalid-low) cycles between consecutive beats of a packet.

module axis_pkt_gen #(
   parameter int LEN_W  = 16,
   parameter int DATA_W = 32,
   parameter int CNT_W  = 16
) (
   input  logic              aclk,
   input  logic              aresetn,
   input  logic              start,
   input  logic [LEN_W-1:0]  cfg_len,
   input  logic [31:0]       cfg_seed,
`ifdef AXIS_PKT_GEN_GAP_EN
   input  logic [7:0]        cfg_gap,
`endif
   output logic              busy,
   output logic              done,
   output logic              err,
   output logic [CNT_W-1:0]  pkt_count,
   output logic [DATA_W-1:0] m_axis_tdata,
   output logic [3:0]        m_axis_tkeep,
   output logic              m_axis_tlast,
   output logic              m_axis_tvalid,
   input  logic              m_axis_tready
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SEND = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t            state;
   state_t            state_nxt;

   logic [LEN_W-2:0]  beats_left;
   logic [DATA_W-1:0] data_q;
   logic [3:0]        last_keep_q;
   logic              err_q;
   logic [CNT_W-1:0]  count_q;

   logic [LEN_W:0]    len_round;
   logic [LEN_W-2:0]  beats_init;
   logic [3:0]        keep_init;
   logic              start_ok;
   logic              start_zero;
   logic              is_last;
   logic              gap_idle;
   logic              handshake;

`ifdef AXIS_PKT_GEN_GAP_EN
   logic [7:0]        gap_q;
   logic [7:0]        gap_cnt;
`endif

   // Decode the start request and derive beat count and final-beat byte enables
   always_comb begin
      len_round  = {1'b0, cfg_len} + (LEN_W+1)'(3);
      beats_init = len_round[LEN_W:2];
      start_ok   = (state == IDLE) && start && (cfg_len != '0);
      start_zero = (state == IDLE) && start && (cfg_len == '0);
      case (cfg_len[1:0])
         2'd1:    keep_init = 4'h1;
         2'd2:    keep_init = 4'h3;
         2'd3:    keep_init = 4'h7;
         default: keep_init = 4'hF;
      endcase
   end

`ifdef AXIS_PKT_GEN_GAP_EN
   assign gap_idle = (gap_cnt == 8'd0);
`else
   assign gap_idle = 1'b1;
`endif

   assign is_last   = (beats_left == (LEN_W-1)'(1));
   assign handshake = m_axis_tvalid && m_axis_tready;

   // State register; reset abandons any packet in flight immediately
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state selection: accept a start, finish on the tlast handshake, DONE lasts one cycle
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start_ok) state_nxt = SEND;
         SEND:    if (handshake && is_last) state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Packet datapath: load on accepted start, step data and beat count on each handshake
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         beats_left  <= '0;
         data_q      <= '0;
         last_keep_q <= 4'h0;
`ifdef AXIS_PKT_GEN_GAP_EN
         gap_q       <= 8'd0;
         gap_cnt     <= 8'd0;
`endif
      end else if (start_ok) begin
         beats_left  <= beats_init;
         data_q      <= cfg_seed;
         last_keep_q <= keep_init;
`ifdef AXIS_PKT_GEN_GAP_EN
         gap_q       <= cfg_gap;
         gap_cnt     <= 8'd0;
`endif
      end else if (state == SEND) begin
         if (handshake) begin
            beats_left <= beats_left - (LEN_W-1)'(1);
            data_q     <= data_q + DATA_W'(1);
`ifdef AXIS_PKT_GEN_GAP_EN
            if (!is_last) begin
               gap_cnt <= gap_q;
            end
`endif
         end
`ifdef AXIS_PKT_GEN_GAP_EN
         else if (gap_cnt != 8'd0) begin
            gap_cnt <= gap_cnt - 8'd1;
         end
`endif
      end
   end

   // Status registers: one-cycle reject pulse and completed-packet counter
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         err_q   <= 1'b0;
         count_q <= '0;
      end else begin
         err_q <= start_zero;
         if ((state == SEND) && handshake && is_last) begin
            count_q <= count_q + CNT_W'(1);
         end
      end
   end

   // Output decode; stream fields are zero outside SEND so reset and idle show all-zero
   always_comb begin
      busy          = 1'b0;
      done          = 1'b0;
      m_axis_tvalid = 1'b0;
      m_axis_tdata  = '0;
      m_axis_tkeep  = 4'h0;
      m_axis_tlast  = 1'b0;
      case (state)
         SEND: begin
            busy          = 1'b1;
            m_axis_tvalid = gap_idle;
            m_axis_tdata  = data_q;
            m_axis_tkeep  = is_last ? last_keep_q : 4'hF;
            m_axis_tlast  = is_last;
         end
         DONE: begin
            done = 1'b1;
         end
         default: begin
         end
      endcase
   end

   assign err       = err_q;
   assign pkt_count = count_q;

endmodule

// File: tb/tb_axis_pkt_gen.sv
// tb_axis_pkt_gen: directed, scoreboard-based bench for axis_pkt_gen.
// Expected beats are queued when a packet is started and popped by a monitor
// on every observed handshake. Build with AXIS_PKT_GEN_GAP_EN to also cover
// the inter-beat gap option.

module tb_axis_pkt_gen;

   localparam int LEN_W = 16;
   localparam int CNT_W = 16;

   typedef struct packed {
      logic [31:0] d;
      logic [3:0]  k;
      logic        l;
   } beat_t;

   logic             aclk;
   logic             aresetn;
   logic             start;
   logic [LEN_W-1:0] cfg_len;
   logic [31:0]      cfg_seed;
   logic [7:0]       cfg_gap;
   logic             busy;
   logic             done;
   logic             err;
   logic [CNT_W-1:0] pkt_count;
   logic [31:0]      m_axis_tdata;
   logic [3:0]       m_axis_tkeep;
   logic             m_axis_tlast;
   logic             m_axis_tvalid;
   logic             m_axis_tready;

   int errors = 0;
   int checks = 0;
   int cycle = 0;
   int done_seen = 0;
   int last_hs_cycle = -10;
   int exp_pkts = 0;
   beat_t exp_q[$];
   int hs_cyc[$];

   logic        prev_stall = 1'b0;
   logic [31:0] prev_data = '0;
   logic [3:0]  prev_keep = '0;
   logic        prev_last = 1'b0;

   axis_pkt_gen #(.LEN_W(LEN_W), .DATA_W(32), .CNT_W(CNT_W)) dut (
      .aclk          (aclk),
      .aresetn       (aresetn),
      .start         (start),
      .cfg_len       (cfg_len),
      .cfg_seed      (cfg_seed),
`ifdef AXIS_PKT_GEN_GAP_EN
      .cfg_gap       (cfg_gap),
`endif
      .busy          (busy),
      .done          (done),
      .err           (err),
      .pkt_count     (pkt_count),
      .m_axis_tdata  (m_axis_tdata),
      .m_axis_tkeep  (m_axis_tkeep),
      .m_axis_tlast  (m_axis_tlast),
      .m_axis_tvalid (m_axis_tvalid),
      .m_axis_tready (m_axis_tready)
   );

   // Free-running clock with a 10-unit period
   initial aclk = 1'b0;
   always #5 aclk = ~aclk;

   // Cycle counter used to time handshakes against the done pulse
   always @(posedge aclk) cycle <= cycle + 1;

   // Single comparison point: counts every check and reports any failure
   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Queue the expected beats of a packet from the length/seed rule
   task automatic pushPacket(input int len, input logic [31:0] seed);
      int    n;
      beat_t b;
      n = (len + 3) / 4;
      for (int k = 0; k < n; k++) begin
         b.d = seed + 32'(k);
         b.l = (k == n - 1);
         if (k == n - 1) begin
            case (len % 4)
               1:       b.k = 4'h1;
               2:       b.k = 4'h3;
               3:       b.k = 4'h7;
               default: b.k = 4'hF;
            endcase
         end else begin
            b.k = 4'hF;
         end
         exp_q.push_back(b);
      end
   endtask

   // Pulse start for one cycle; returns #1 after the edge that captured it
   task automatic applyStimulus(input int len, input logic [31:0] seed, input logic [7:0] gap);
      @(posedge aclk); #1;
      cfg_len  = LEN_W'(len);
      cfg_seed = seed;
      cfg_gap  = gap;
      start    = 1'b1;
      @(posedge aclk); #1;
      start    = 1'b0;
   endtask

   // Wait (bounded) for the done pulse count to reach target, then check the scoreboard drained
   task automatic waitDone(input int target, input int budget);
      int n;
      n = 0;
      while (done_seen < target && n < budget) begin
         @(posedge aclk); #1;
         n++;
      end
      if (done_seen < target) checkOutput("done_timeout", 32'(done_seen), 32'(target));
      checkOutput("sb_empty", 32'(exp_q.size()), 32'd0);
   endtask

   // Monitor: scores handshakes, checks stall stability and done timing/count
   always @(negedge aclk) begin
      beat_t b;
      if (!aresetn) begin
         prev_stall = 1'b0;
         exp_pkts   = 0;
      end else begin
         if (prev_stall) begin
            checkOutput("hold_tvalid", 32'(m_axis_tvalid), 32'd1);
            checkOutput("hold_tdata", m_axis_tdata, prev_data);
            checkOutput("hold_tkeep", 32'(m_axis_tkeep), 32'(prev_keep));
            checkOutput("hold_tlast", 32'(m_axis_tlast), 32'(prev_last));
         end
         if (m_axis_tvalid) checkOutput("busy_in_send", 32'(busy), 32'd1);
         if (m_axis_tvalid && m_axis_tready) begin
            if (exp_q.size() == 0) begin
               checkOutput("extra_beat", 32'(exp_q.size()), 32'd1);
            end else begin
               b = exp_q.pop_front();
               checkOutput("tdata", m_axis_tdata, b.d);
               checkOutput("tkeep", 32'(m_axis_tkeep), 32'(b.k));
               checkOutput("tlast", 32'(m_axis_tlast), 32'(b.l));
            end
            last_hs_cycle = cycle;
            hs_cyc.push_back(cycle);
         end
         if (done) begin
            done_seen++;
            exp_pkts++;
            checkOutput("done_latency", 32'(cycle), 32'(last_hs_cycle + 1));
            checkOutput("done_tvalid", 32'(m_axis_tvalid), 32'd0);
            checkOutput("done_busy", 32'(busy), 32'd0);
            checkOutput("pkt_count", 32'(pkt_count), 32'(exp_pkts));
         end
         prev_stall = m_axis_tvalid && !m_axis_tready;
         prev_data  = m_axis_tdata;
         prev_keep  = m_axis_tkeep;
         prev_last  = m_axis_tlast;
      end
   end

   // Global watchdog so the run always terminates
   initial begin
      #100000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   // Directed test sequence
   initial begin
      int d0;
      aresetn       = 1'b0;
      start         = 1'b0;
      cfg_len       = '0;
      cfg_seed      = '0;
      cfg_gap       = '0;
      m_axis_tready = 1'b0;
      repeat (3) @(posedge aclk);
      #1;
      checkOutput("rst_tvalid", 32'(m_axis_tvalid), 32'd0);
      checkOutput("rst_tdata", m_axis_tdata, 32'd0);
      checkOutput("rst_tkeep", 32'(m_axis_tkeep), 32'd0);
      checkOutput("rst_tlast", 32'(m_axis_tlast), 32'd0);
      checkOutput("rst_busy", 32'(busy), 32'd0);
      checkOutput("rst_done", 32'(done), 32'd0);
      checkOutput("rst_err", 32'(err), 32'd0);
      checkOutput("rst_pkt_count", 32'(pkt_count), 32'd0);
      aresetn = 1'b1;
      repeat (2) @(posedge aclk);

      $display("[TB] 128-byte packet, seed 0, tready high");
      m_axis_tready = 1'b1;
      pushPacket(128, 32'h0);
      applyStimulus(128, 32'h0, 8'd0);
      checkOutput("first_tvalid", 32'(m_axis_tvalid), 32'd1);
      waitDone(1, 100);
      checkOutput("pkt_count_1", 32'(pkt_count), 32'd1);

      $display("[TB] 5-byte packet, seed 0x100");
      pushPacket(5, 32'h100);
      applyStimulus(5, 32'h100, 8'd0);
      waitDone(2, 20);

      $display("[TB] 16-byte packet with sparse tready");
      m_axis_tready = 1'b0;
      pushPacket(16, 32'hCAFE_0000);
      applyStimulus(16, 32'hCAFE_0000, 8'd0);
      repeat (4) begin
         m_axis_tready = 1'b1;
         @(posedge aclk); #1;
         m_axis_tready = 1'b0;
         repeat (100) @(posedge aclk);
         #1;
      end
      waitDone(3, 20);

      $display("[TB] zero-length start is rejected");
      m_axis_tready = 1'b1;
      applyStimulus(0, 32'h1234, 8'd0);
      checkOutput("err_pulse", 32'(err), 32'd1);
      checkOutput("err_tvalid", 32'(m_axis_tvalid), 32'd0);
      @(posedge aclk); #1;
      checkOutput("err_clear", 32'(err), 32'd0);
      checkOutput("err_tvalid2", 32'(m_axis_tvalid), 32'd0);
      checkOutput("err_pkt_count", 32'(pkt_count), 32'd3);

      $display("[TB] start during SEND is ignored");
      m_axis_tready = 1'b0;
      pushPacket(8, 32'hA0);
      applyStimulus(8, 32'hA0, 8'd0);
      applyStimulus(100, 32'h5555, 8'd0);
      checkOutput("ign_tdata", m_axis_tdata, 32'hA0);
      checkOutput("ign_err", 32'(err), 32'd0);
      m_axis_tready = 1'b1;
      waitDone(4, 20);

      $display("[TB] data wrap across 2^32");
      pushPacket(12, 32'hFFFF_FFFE);
      applyStimulus(12, 32'hFFFF_FFFE, 8'd0);
      waitDone(5, 20);

      $display("[TB] reset mid-packet");
      exp_q.push_back('{d: 32'h40, k: 4'hF, l: 1'b0});
      applyStimulus(12, 32'h40, 8'd0);
      @(posedge aclk); #1;
      checkOutput("pre_rst_tdata", m_axis_tdata, 32'h41);
      d0 = done_seen;
      aresetn = 1'b0;
      #1;
      checkOutput("midrst_tvalid", 32'(m_axis_tvalid), 32'd0);
      checkOutput("midrst_busy", 32'(busy), 32'd0);
      checkOutput("midrst_pkt_count", 32'(pkt_count), 32'd0);
      checkOutput("midrst_sb_empty", 32'(exp_q.size()), 32'd0);
      repeat (3) @(posedge aclk);
      #1;
      aresetn = 1'b1;
      repeat (10) @(posedge aclk);
      #1;
      checkOutput("midrst_no_done", 32'(done_seen), 32'(d0));
      checkOutput("midrst_tvalid_after", 32'(m_axis_tvalid), 32'd0);
      checkOutput("midrst_count_after", 32'(pkt_count), 32'd0);

`ifdef AXIS_PKT_GEN_GAP_EN
      $display("[TB] inter-beat gap of 3 cycles");
      hs_cyc.delete();
      pushPacket(12, 32'h700);
      applyStimulus(12, 32'h700, 8'd3);
      waitDone(d0 + 1, 40);
      checkOutput("gap_beats", 32'(hs_cyc.size()), 32'd3);
      if (hs_cyc.size() == 3) begin
         checkOutput("gap_0_1", 32'(hs_cyc[1] - hs_cyc[0]), 32'd4);
         checkOutput("gap_1_2", 32'(hs_cyc[2] - hs_cyc[1]), 32'd4);
      end
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/axis_pkt_gen.md
Name: axis_pkt_gen

Overview:
- AXI4-Stream master packet source; the transmit-side counterpart of the MM2S-to-stream-slave path.
- Drives the AXI DMA S2MM slave port (or a stream-slave VIP) with deterministic incrementing-word packets, so the S2MM path into BRAM/DDR can be checked word for word.
- Configured by a processor-visible register block via a start pulse; reports busy/done/err and a completed-packet count.

Parameters:
- LEN_W, 16, width of the packet byte-length input (max packet 2^LEN_W-1 bytes)
- DATA_W, 32, stream data width in bits; fixed at 32 (tkeep is 4 bits)
- CNT_W, 16, width of the completed-packet counter

Ports:
- aclk  input  1  single clock for all logic
- aresetn  input  1  asynchronous active-low reset
- start  input  1  single-cycle start request
- cfg_len  input  LEN_W  packet length in bytes
- cfg_seed  input  32  data value of the first beat
- busy  output  1  high while a packet is in progress
- done  output  1  one-cycle pulse after the last beat completes
- err  output  1  one-cycle pulse when a zero-length start is rejected
- pkt_count  output  CNT_W  number of completed packets; wraps
- m_axis_tdata  output  32  stream data
- m_axis_tkeep  output  4  byte enables
- m_axis_tlast  output  1  marks the final beat
- m_axis_tvalid  output  1  stream valid
- m_axis_tready  input  1  stream ready from the slave

Behaviour:
- Reset (async assert, sync release): state IDLE. All outputs are 0, including tvalid, tdata, tkeep, tlast, busy, done, err and pkt_count. Reset mid-packet drops tvalid immediately; the partial packet is abandoned with no done pulse.
- States: IDLE, SEND, DONE.
- IDLE:
  - start with cfg_len != 0: latch len and seed, load beat counter, go to SEND. tvalid rises on the next cycle; start-to-first-tvalid latency is 1 cycle.
  - start with cfg_len == 0: err pulses for 1 cycle; stay in IDLE.
- SEND:
  - busy = 1.
  - Beats = ceil(len/4).
  - Beat k has tdata = seed + k, mod 2^32.
  - tkeep = 4'hF on all beats except the last. Last beat tkeep: len%4 = 0 -> F, 1 -> 1, 2 -> 3, 3 -> 7.
  - tlast = 1 only on the last beat.
  - A beat advances only on tvalid && tready.
  - While tvalid && !tready, tdata, tkeep and tlast hold stable and tvalid stays high.
  - tvalid never depends combinationally on tready.
  - With tready held high, one beat completes per cycle.
  - On the handshake of the tlast beat: go to DONE and drop tvalid.
- DONE: lasts 1 cycle. done = 1, pkt_count increments (wraps at 2^CNT_W), busy = 0, then return to IDLE.
- start while in SEND or DONE is ignored; neither the latched len nor the latched seed changes.
- A start accepted on the cycle after DONE begins a new packet. Minimum packet-to-packet spacing is therefore 2 idle-tvalid cycles.
- One-beat packet (len 1..4): the first beat is also the last.

Optional Feature:
- Macro AXIS_PKT_GEN_GAP_EN.
- Defined:
  - Adds input port cfg_gap [7:0], latched at start.
  - After each completed beat handshake except the last, tvalid stays low for cfg_gap cycles before the next beat is presented.
  - cfg_gap = 0 behaves identically to the macro-absent build.
- Undefined: the cfg_gap port does not exist; beats are back-to-back whenever tready allows.

Test Plan:
- cfg_len=128, seed=0, tready tied 1, start -> 32 consecutive beats with tdata 0..31 and tkeep F; tlast only on beat 31; done 1 cycle after that handshake; pkt_count=1.
- cfg_len=5, seed=32'h100 -> 2 beats: 32'h100 with tkeep F, then 32'h101 with tkeep 1 and tlast=1.
- cfg_len=16, tready high for 1 cycle then low for 100 cycles, repeating -> 4 beats, each held stable while tready is low; done after the 4th handshake; no beat dropped or duplicated.
- cfg_len=0 -> err pulse; tvalid stays 0; pkt_count unchanged. Second start pulse during SEND -> ignored; packet length unchanged.
- seed=32'hFFFF_FFFE, cfg_len=12 -> tdata FFFF_FFFE, FFFF_FFFF, 0000_0000. Then aresetn asserted mid-packet at beat 1 -> tvalid=0 the same cycle; no done; pkt_count=0.
- With AXIS_PKT_GEN_GAP_EN, cfg_gap=3, cfg_len=12, tready=1 -> beats spaced with exactly 3 tvalid-low cycles between them; no gap after the last beat.
